rf80386_biu: RTL and testbench
==============================

// Module: rf80386_biu
// PURPOSE
// - Parametrised multi-byte bus interface unit for the rf80386 core; replaces per-byte data accesses on the 128-bit fta bus.
// - Takes one 1..MAX_BYTES access from the execute FSM, lane-aligns it, and splits it into two transactions when it crosses a 16-byte line.
// - Allocates transaction ids, honours retry with back-off, applies a timeout, and returns assembled read data with a one-cycle done pulse.
// PARAMETERS
// - CORENO     6'd1   core number driven on ftam_req.tid.core
// - CID        3'd1   channel driven on ftam_req.tid.channel
// - MAX_BYTES  8      largest access size in bytes (1..8)
// - RTY_WAIT   16     idle cycles after a rty before the request is reissued
// - TO_CYCLES  255    cycles without ack/rty/err before the access aborts with err_o
// PORTS
// - clk_i     in   1     clock; all logic on posedge
// - rst_i     in   1     synchronous, active-high reset
// - req_i     in   1     access request; sampled only while busy_o=0
// - we_i      in   1     1=write, 0=read
// - adr_i     in   32    linear byte address
// - size_i    in   4     access size in bytes
// - wdat_i    in   64    write data, little-endian, byte 0 = lowest address
// - busy_o    out  1     access in progress
// - done_o    out  1     one-cycle completion pulse
// - err_o     out  1     valid with done_o: bad size, bus error or timeout
// - rdat_o    out  64    read data, zero-extended above size_i bytes; held until the next done_o
// - ftam_req  out  fta_cmd_request128_t   bus request
// - ftam_resp in   fta_cmd_response128_t  bus response (ack, rty, err, tid, dat)
// BEHAVIOUR
// - Reset values: busy_o=0, done_o=0, err_o=0, rdat_o=0. ftam_req is all zero except tid.core=CORENO and tid.channel=CID. tid counter=1. FSM in IDLE.
// - Reset mid-access aborts without a done_o pulse. Late responses are ignored because their tid no longer matches.
// - FSM states: IDLE -> ISSUE -> WAIT -> (RETRY -> ISSUE) -> [second half: ISSUE -> WAIT] -> DONE -> IDLE.
// - IDLE: on req_i, latch all inputs and set busy_o. size_i=0 or size_i>MAX_BYTES goes straight to DONE with err_o=1 and no bus cycle.
// - Split rule, with off=adr[3:0]:
//   - off+size<=16: one transaction, sel=((1<<size)-1)<<off.
//   - otherwise: first transaction covers off..15; second covers bytes 0..(off+size-17) at line adr[31:4]+1, address wraps mod 2^32.
// - Second half is issued only after the first half's ack. Never two transactions in flight.
// - ISSUE: drive cyc=stb=1, we, sel, adr={line,4'h0}, cmd=CMD_LOAD/CMD_STORE for exactly one cycle.
//   - Write data = wdat << 8*off for the first half, wdat >> 8*(16-off) for the second half.
//   - All other cycles drive tClearBus-equivalent idle values.
// - tid: each ISSUE takes a new tranid, sequence 1,2..15,1. Tranid 0 is never issued and marks an idle bus.
// - WAIT: only responses whose tid.tranid equals the issued id count. A timeout counter starts at 0 on ISSUE.
//   - ack: first half stores (dat>>8*off) into bytes 0..(15-off); second half stores dat bytes 0.. into rdat from byte (16-off).
//   - err, or counter==TO_CYCLES: go to DONE with err_o=1 and discard the remaining half.
//   - rty: go to RETRY, wait RTY_WAIT cycles, then reissue the same half with a fresh tid.
//   - ack and rty in the same cycle: ack wins.
// - DONE: done_o=1 for one cycle and busy_o drops in that same cycle; rdat_o and err_o are registered. A new req_i is accepted the following cycle.
// - Latency: unsplit access with req_i sampled at T issues at T+1. Ack at T+1+L gives done_o at T+2+L. A split access adds 1 cycle plus the second ack latency.
// STRUCTURE
// - rf80386_pkg additions:
//   - e_biu_state enum {BIU_IDLE, BIU_ISSUE, BIU_WAIT, BIU_RETRY, BIU_DONE}
//   - constant BIU_LINE_BYTES=16
// - Sub-module rf80386_lane_align (combinational): off, size, half, wdat -> sel, wide write data, read-merge byte enables.
// - tid counter and timeout counter stay inline.
// TESTING
// - Read adr=0x1000 size=4, ack L=2 with dat bytes 0..3=11,22,33,44 -> sel=0x000F; rdat_o=0x44332211; done_o at T+4; err_o=0.
// - Write adr=0x100E size=4 wdat=0xAABBCCDD -> tx1 sel=0xC000 at 0x1000 carrying DD,CC in bytes 14,15; tx2 sel=0x0003 at 0x1010 carrying BB,AA; tids 1,2.
// - rty on first issue -> 16 idle cycles, then reissue with tid+1; a stale ack with the old tid is ignored; completes with err_o=0.
// - No response for 255 cycles -> done_o with err_o=1, busy_o falls. size_i=0 -> done_o+err_o at T+1 and no cyc on the bus.
// - 16 back-to-back accesses -> tranid sequence 1..15 then 1; tranid 0 never appears.
// - rst_i asserted during WAIT of a split read -> next cycle busy_o=0, cyc=0, no done_o; the subsequent access is issued with tid 1.

Source files
------------

// File: rtl/rf80386_biu_pkg.sv
// Shared types for the rf80386 bus interface unit: BIU FSM states, fta bus
// request/response structs, line geometry and the transaction-id step.
// Types only; no latency, no backpressure.
package rf80386_biu_pkg;

   localparam int BIU_LINE_BYTES = 16;

   typedef enum logic [2:0] {
      BIU_IDLE,
      BIU_ISSUE,
      BIU_WAIT,
      BIU_RETRY,
      BIU_DONE
   } e_biu_state;

   typedef enum logic [4:0] {
      CMD_NONE  = 5'd0,
      CMD_LOAD  = 5'd1,
      CMD_STORE = 5'd2
   } fta_cmd_t;

   typedef struct packed {
      logic [5:0] core;
      logic [2:0] channel;
      logic [3:0] tranid;
   } fta_tranid_t;

   typedef struct packed {
      fta_cmd_t     cmd;
      fta_tranid_t  tid;
      logic         cyc;
      logic         stb;
      logic         we;
      logic [15:0]  sel;
      logic [31:0]  adr;
      logic [127:0] data1;
   } fta_cmd_request128_t;

   typedef struct packed {
      fta_tranid_t  tid;
      logic         ack;
      logic         rty;
      logic         err;
      logic [127:0] dat;
   } fta_cmd_response128_t;

   // Tranid 0 marks an idle bus, so the sequence runs 1..15 and wraps to 1.
   function automatic logic [3:0] next_tranid(input logic [3:0] t);
      return (t == 4'd15) ? 4'd1 : t + 4'd1;
   endfunction

endpackage

// File: rtl/rf80386_biu_if.sv
// fta 128-bit command bus between a master (the BIU) and a slave (memory side).
// Signals: ftam_req (master -> slave), ftam_resp (slave -> master).
// No storage; latency and backpressure are set by the endpoints (ack/rty/err).
interface rf80386_biu_if;
   import rf80386_biu_pkg::*;

   fta_cmd_request128_t  ftam_req;
   fta_cmd_response128_t ftam_resp;

   modport master (output ftam_req, input ftam_resp);
   modport slave  (input ftam_req, output ftam_resp);
endinterface

// File: rtl/rf80386_biu_lane_align.sv
// Lane alignment for one half of a BIU access: byte selects, shifted write data,
// shifted read data and the rdat byte enables this half contributes.
// Purely combinational (0 cycles); no backpressure.
// Ports: off/size/half/wdat/line_dat in; sel/wide_dat/rd_dat/rd_be out.
module rf80386_lane_align
   import rf80386_biu_pkg::*;
(
   input  logic [3:0]   off,
   input  logic [3:0]   size,
   input  logic         half,
   input  logic [63:0]  wdat,
   input  logic [127:0] line_dat,
   output logic [15:0]  sel,
   output logic [127:0] wide_dat,
   output logic [63:0]  rd_dat,
   output logic [7:0]   rd_be
);
   // The access is viewed as a 32-byte window spanning two lines; the first
   // half lives in the low line, the second half in the high line.
   logic [31:0]  mask;
   logic [255:0] wr_span;

   always_comb begin
      rd_be    = '0;
      mask     = ((32'd1 << size) - 32'd1) << off;
      wr_span  = {192'd0, wdat} << {off, 3'b000};
      sel      = half ? mask[31:16] : mask[15:0];
      wide_dat = half ? wr_span[255:128] : wr_span[127:0];
      rd_dat   = 64'((half ? {line_dat, 128'd0} : {128'd0, line_dat}) >> {off, 3'b000});
      // rdat byte k comes from the first line when off+k is still inside it.
      for (int k = 0; k < 8; k++)
         rd_be[k] = (k < int'(size)) && (((int'(off) + k) < BIU_LINE_BYTES) != half);
   end

endmodule

// File: rtl/rf80386_biu.sv
// Multi-byte bus interface unit: one 1..MAX_BYTES access, split at 16-byte lines.
// Latency: issue 1 cycle after req_i, done_o 1 cycle after the final ack.
// Backpressure: busy_o blocks new requests; rty backs off RTY_WAIT cycles.
// Ports: clk_i, rst_i (sync, active-high), req_i/we_i/adr_i/size_i/wdat_i in;
//        busy_o/done_o/err_o/rdat_o out; ftam (fta master: ftam_req/ftam_resp).
module rf80386_biu
   import rf80386_biu_pkg::*;
#(
   parameter logic [5:0] CORENO    = 6'd1,
   parameter logic [2:0] CID       = 3'd1,
   parameter int         MAX_BYTES = 8,
   parameter int         RTY_WAIT  = 16,
   parameter int         TO_CYCLES = 255
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               req_i,
   input  logic               we_i,
   input  logic [31:0]        adr_i,
   input  logic [3:0]         size_i,
   input  logic [63:0]        wdat_i,
   output logic               busy_o,
   output logic               done_o,
   output logic               err_o,
   output logic [63:0]        rdat_o,
   rf80386_biu_if.master      ftam
);
   localparam int         TO_W   = $clog2(TO_CYCLES + 1);
   localparam int         RTY_W  = $clog2(RTY_WAIT + 1);
   localparam logic [3:0] MAX_SZ = 4'(MAX_BYTES);

   e_biu_state          state, state_nxt;
   logic                we_r, half_r;
   logic [31:0]         adr_r;
   logic [3:0]          size_r;
   logic [63:0]         wdat_r, rdat_acc, rdat_merged;
   logic [3:0]          tid_cnt, cur_tid;
   logic [TO_W-1:0]     to_cnt;
   logic [RTY_W-1:0]    rty_cnt;
   logic                split, resp_hit, bad_size;
   logic [15:0]         la_sel;
   logic [127:0]        la_wide;
   logic [63:0]         la_rd_dat;
   logic [7:0]          la_rd_be;
   fta_cmd_request128_t req_d;

   rf80386_lane_align u_align (
      .off      (adr_r[3:0]),
      .size     (size_r),
      .half     (half_r),
      .wdat     (wdat_r),
      .line_dat (ftam.ftam_resp.dat),
      .sel      (la_sel),
      .wide_dat (la_wide),
      .rd_dat   (la_rd_dat),
      .rd_be    (la_rd_be)
   );

   assign split    = ({1'b0, adr_r[3:0]} + {1'b0, size_r}) > 5'd16;
   assign bad_size = (size_i == 4'd0) || (size_i > MAX_SZ);
   // A response counts only if its whole tid matches the outstanding one;
   // anything from an earlier (aborted or retried) issue is dropped.
   assign resp_hit = (ftam.ftam_resp.tid == {CORENO, CID, cur_tid});
   assign busy_o   = (state != BIU_IDLE) && (state != BIU_DONE);
   assign done_o   = (state == BIU_DONE);

   always_comb begin
      state_nxt = state;
      case (state)
         BIU_IDLE:  if (req_i) state_nxt = bad_size ? BIU_DONE : BIU_ISSUE;
         BIU_ISSUE: state_nxt = BIU_WAIT;
         BIU_WAIT: begin
            if (resp_hit && ftam.ftam_resp.ack)
               state_nxt = (split && !half_r) ? BIU_ISSUE : BIU_DONE;
            else if (resp_hit && ftam.ftam_resp.err)
               state_nxt = BIU_DONE;
            else if (resp_hit && ftam.ftam_resp.rty)
               state_nxt = BIU_RETRY;
            else if (to_cnt == TO_W'(TO_CYCLES))
               state_nxt = BIU_DONE;
         end
         BIU_RETRY: if (rty_cnt == RTY_W'(RTY_WAIT - 1)) state_nxt = BIU_ISSUE;
         BIU_DONE:  state_nxt = BIU_IDLE;
         default:   state_nxt = BIU_IDLE;
      endcase
   end

   // Writes never merge returned data into the read result.
   always_comb begin
      rdat_merged = rdat_acc;
      for (int k = 0; k < 8; k++)
         if (la_rd_be[k] && !we_r) rdat_merged[8*k +: 8] = la_rd_dat[8*k +: 8];
   end

   always_comb begin
      req_d             = '0;
      req_d.cmd         = CMD_NONE;
      req_d.tid.core    = CORENO;
      req_d.tid.channel = CID;
      if (state == BIU_ISSUE) begin
         req_d.cmd        = we_r ? CMD_STORE : CMD_LOAD;
         req_d.tid.tranid = tid_cnt;
         req_d.cyc        = 1'b1;
         req_d.stb        = 1'b1;
         req_d.we         = we_r;
         req_d.sel        = la_sel;
         req_d.adr        = {adr_r[31:4] + {27'd0, half_r}, 4'h0};
         req_d.data1      = we_r ? la_wide : '0;
      end
   end
   assign ftam.ftam_req = req_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= BIU_IDLE;
         we_r     <= 1'b0;
         half_r   <= 1'b0;
         adr_r    <= '0;
         size_r   <= '0;
         wdat_r   <= '0;
         rdat_acc <= '0;
         rdat_o   <= '0;
         err_o    <= 1'b0;
         tid_cnt  <= 4'd1;
         cur_tid  <= 4'd0;
         to_cnt   <= '0;
         rty_cnt  <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            BIU_IDLE: if (req_i) begin
               we_r     <= we_i;
               adr_r    <= adr_i;
               size_r   <= size_i;
               wdat_r   <= wdat_i;
               half_r   <= 1'b0;
               rdat_acc <= '0;
               if (bad_size) begin
                  err_o  <= 1'b1;
                  rdat_o <= '0;
               end
            end
            BIU_ISSUE: begin
               cur_tid <= tid_cnt;
               tid_cnt <= next_tranid(tid_cnt);
               to_cnt  <= '0;
            end
            BIU_WAIT: begin
               to_cnt <= to_cnt + TO_W'(1);
               if (resp_hit && ftam.ftam_resp.ack) begin
                  rdat_acc <= rdat_merged;
                  if (state_nxt == BIU_ISSUE) begin
                     half_r <= 1'b1;
                  end else begin
                     rdat_o <= rdat_merged;
                     err_o  <= 1'b0;
                  end
               end else if (state_nxt == BIU_DONE) begin
                  // err or timeout: any pending second half is dropped
                  rdat_o <= '0;
                  err_o  <= 1'b1;
               end
               if (state_nxt == BIU_RETRY) rty_cnt <= '0;
            end
            BIU_RETRY: rty_cnt <= rty_cnt + RTY_W'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rf80386_biu.sv
// Directed bench for rf80386_biu: the bench plays the fta slave, drives and
// samples on the falling edge, and checks against hand-computed vectors.
module tb_rf80386_biu;
   import rf80386_biu_pkg::*;

   logic        clk = 1'b0;
   logic        rst, req, we;
   logic [31:0] adr;
   logic [3:0]  size;
   logic [63:0] wdat;
   logic        busy, done, err;
   logic [63:0] rdat;

   int n_vec = 0;
   int n_bad = 0;

   fta_cmd_request128_t cap;
   bit                  ok;

   always #5 clk = ~clk;

   rf80386_biu_if bus ();

   rf80386_biu dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .req_i  (req),
      .we_i   (we),
      .adr_i  (adr),
      .size_i (size),
      .wdat_i (wdat),
      .busy_o (busy),
      .done_o (done),
      .err_o  (err),
      .rdat_o (rdat),
      .ftam   (bus)
   );

   task automatic do_reset();
      rst = 1'b1; req = 1'b0; we = 1'b0; adr = '0; size = '0; wdat = '0;
      bus.ftam_resp = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [63:0] d);
      @(negedge clk);
      req = 1'b1; we = w; adr = a; size = s; wdat = d;
   endtask

   task automatic wait_cyc(output fta_cmd_request128_t r, output bit found);
      found = 1'b0;
      r     = '0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (bus.ftam_req.cyc) begin
            r = bus.ftam_req;
            found = 1'b1;
         end else begin
            @(negedge clk);
            req = 1'b0;
         end
      end
   endtask

   task automatic respond(input int lat, input logic a, input logic r, input logic e,
                          input logic [3:0] t, input logic [127:0] d);
      repeat (lat) @(negedge clk);
      bus.ftam_resp.tid.core    = 6'd1;
      bus.ftam_resp.tid.channel = 3'd1;
      bus.ftam_resp.tid.tranid  = t;
      bus.ftam_resp.ack         = a;
      bus.ftam_resp.rty         = r;
      bus.ftam_resp.err         = e;
      bus.ftam_resp.dat         = d;
      @(negedge clk);
      bus.ftam_resp = '0;
   endtask

   task automatic test_reset();
      fta_cmd_request128_t idle_req;
      idle_req = '0;
      idle_req.tid.core = 6'd1;
      idle_req.tid.channel = 3'd1;
      do_reset();
      @(negedge clk);
      n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
      n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
      n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
      n_vec++; if (rdat !== 64'd0) begin n_bad++; $display("FAIL reset_rdat got %h want 0", rdat); end
      n_vec++; if (bus.ftam_req !== idle_req) begin n_bad++; $display("FAIL reset_req got %h want %h", bus.ftam_req, idle_req); end
   endtask

   task automatic test_read();
      do_reset();
      issue(1'b0, 32'h0000_1000, 4'd4, 64'd0);
      wait_cyc(cap, ok);
      n_vec++; if (!ok) begin n_bad++; $display("FAIL rd_cyc got none want cyc"); end
      n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rd_busy got %b want 1", busy); end
      n_vec++; if (cap.sel !== 16'h000F) begin n_bad++; $display("FAIL rd_sel got %h want 000f", cap.sel); end
      n_vec++; if (cap.adr !== 32'h0000_1000) begin n_bad++; $display("FAIL rd_adr got %h want 00001000", cap.adr); end
      n_vec++; if (cap.cmd !== CMD_LOAD || cap.we !== 1'b0) begin n_bad++; $display("FAIL rd_cmd got %0d/%b want load/0", cap.cmd, cap.we); end
      n_vec++; if (cap.tid.tranid !== 4'd1) begin n_bad++; $display("FAIL rd_tid got %0d want 1", cap.tid.tranid); end
      respond(2, 1'b1, 1'b0, 1'b0, 4'd1, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_4433_2211);
      n_vec++; if (done !== 1'b1) begin n_bad++; $display("FAIL rd_done_t4 got %b want 1", done); end
      n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL rd_err got %b want 0", err); end
      n_vec++; if (rdat !== 64'h0000_0000_4433_2211) begin n_bad++; $display("FAIL rd_rdat got %h want 44332211", rdat); end
      @(negedge clk);
      n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL rd_done_pulse got %b want 0", done); end
      n_vec++; if (rdat !== 64'h0000_0000_4433_2211) begin n_bad++; $display("FAIL rd_rdat_hold got %h want 44332211", rdat); end
   endtask

   task automatic test_split_write();
      do_reset();
      issue(1'b1, 32'h0000_100E, 4'd4, 64'h0000_0000_AABB_CCDD);
      wait_cyc(cap, ok);
      n_vec++; if (!ok) begin n_bad++; $display("FAIL wr1_cyc got none want cyc"); end
      n_vec++; if (cap.sel !== 16'hC000 || cap.adr !== 32'h0000_1000) begin n_bad++; $display("FAIL wr1_sel_adr got %h/%h want c000/00001000", cap.sel, cap.adr); end
      n_vec++; if (cap.data1[127:112] !== 16'hCCDD) begin n_bad++; $display("FAIL wr1_dat got %h want ccdd", cap.data1[127:112]); end
      n_vec++; if (cap.cmd !== CMD_STORE || cap.we !== 1'b1 || cap.tid.tranid !== 4'd1) begin n_bad++; $display("FAIL wr1_cmd_tid got %0d/%b/%0d want store/1/1", cap.cmd, cap.we, cap.tid.tranid); end
      respond(1, 1'b1, 1'b0, 1'b0, 4'd1, '0);
      wait_cyc(cap, ok);
      n_vec++; if (!ok || done !== 1'b0) begin n_bad++; $display("FAIL wr2_cyc got %b/%b want 1/0", ok, done); end
      n_vec++; if (cap.sel !== 16'h0003 || cap.adr !== 32'h0000_1010) begin n_bad++; $display("FAIL wr2_sel_adr got %h/%h want 0003/00001010", cap.sel, cap.adr); end
      n_vec++; if (cap.data1[15:0] !== 16'hAABB) begin n_bad++; $display("FAIL wr2_dat got %h want aabb", cap.data1[15:0]); end
      n_vec++; if (cap.tid.tranid !== 4'd2) begin n_bad++; $display("FAIL wr2_tid got %0d want 2", cap.tid.tranid); end
      respond(1, 1'b1, 1'b0, 1'b0, 4'd2, '0);
      n_vec++; if (done !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL wr_done got %b/%b want 1/0", done, err); end
   endtask

   task automatic test_split_read_wrap();
      do_reset();
      issue(1'b0, 32'hFFFF_FFFD, 4'd6, 64'd0);
      wait_cyc(cap, ok);
      n_vec++; if (!ok || cap.sel !== 16'hE000 || cap.adr !== 32'hFFFF_FFF0) begin n_bad++; $display("FAIL srd1 got %b/%h/%h want 1/e000/fffffff0", ok, cap.sel, cap.adr); end
      respond(1, 1'b1, 1'b0, 1'b0, 4'd1, {24'h030201, {13{8'h77}}});
      wait_cyc(cap, ok);
      n_vec++; if (!ok || cap.sel !== 16'h0007 || cap.adr !== 32'h0000_0000) begin n_bad++; $display("FAIL srd2 got %b/%h/%h want 1/0007/00000000", ok, cap.sel, cap.adr); end
      respond(1, 1'b1, 1'b0, 1'b0, 4'd2, {{13{8'h99}}, 24'h060504});
      n_vec++; if (done !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL srd_done got %b/%b want 1/0", done, err); end
      n_vec++; if (rdat !== 64'h0000_0605_0403_0201) begin n_bad++; $display("FAIL srd_rdat got %h want 0000060504030201", rdat); end
   endtask

   task automatic test_retry();
      int gap;
      do_reset();
      issue(1'b0, 32'h0000_2000, 4'd2, 64'd0);
      wait_cyc(cap, ok);
      n_vec++; if (!ok || cap.tid.tranid !== 4'd1) begin n_bad++; $display("FAIL rty_tid1 got %b/%0d want 1/1", ok, cap.tid.tranid); end
      respond(1, 1'b0, 1'b1, 1'b0, 4'd1, '0);
      gap = 0;
      while (!bus.ftam_req.cyc && gap < 100) begin
         gap++;
         @(negedge clk);
      end
      cap = bus.ftam_req;
      n_vec++; if (gap != 16) begin n_bad++; $display("FAIL rty_gap got %0d want 16", gap); end
      n_vec++; if (cap.tid.tranid !== 4'd2 || cap.adr !== 32'h0000_2000) begin n_bad++; $display("FAIL rty_reissue got %0d/%h want 2/00002000", cap.tid.tranid, cap.adr); end
      respond(1, 1'b1, 1'b0, 1'b0, 4'd1, 128'h1234);
      n_vec++; if (done !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL rty_stale got %b/%b want 0/1", done, busy); end
      respond(1, 1'b1, 1'b0, 1'b0, 4'd2, {{14{8'h55}}, 16'hBEEF});
      n_vec++; if (done !== 1'b1 || err !== 1'b0 || rdat !== 64'h0000_0000_0000_BEEF) begin n_bad++; $display("FAIL rty_done got %b/%b/%h want 1/0/beef", done, err, rdat); end
   endtask

   task automatic test_timeout();
      int cnt;
      do_reset();
      issue(1'b0, 32'h0000_3000, 4'd1, 64'd0);
      wait_cyc(cap, ok);
      n_vec++; if (!ok) begin n_bad++; $display("FAIL to_cyc got none want cyc"); end
      cnt = 0;
      while (!done && cnt < 400) begin
         @(negedge clk);
         cnt++;
      end
      n_vec++; if (done !== 1'b1 || err !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL to_done got %b/%b/%b want 1/1/0", done, err, busy); end
      n_vec++; if (cnt < 255 || cnt > 260) begin n_bad++; $display("FAIL to_cycles got %0d want 255..260", cnt); end
   endtask

   task automatic test_bad_size();
      do_reset();
      issue(1'b0, 32'h0000_4000, 4'd0, 64'd0);
      @(negedge clk);
      req = 1'b0;
      n_vec++; if (done !== 1'b1 || err !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL sz0_done got %b/%b/%b want 1/1/0", done, err, busy); end
      n_vec++; if (bus.ftam_req.cyc !== 1'b0) begin n_bad++; $display("FAIL sz0_cyc got %b want 0", bus.ftam_req.cyc); end
      @(negedge clk);
      n_vec++; if (done !== 1'b0 || bus.ftam_req.cyc !== 1'b0) begin n_bad++; $display("FAIL sz0_after got %b/%b want 0/0", done, bus.ftam_req.cyc); end
      issue(1'b0, 32'h0000_4000, 4'd9, 64'd0);
      @(negedge clk);
      req = 1'b0;
      n_vec++; if (done !== 1'b1 || err !== 1'b1 || bus.ftam_req.cyc !== 1'b0) begin n_bad++; $display("FAIL sz9 got %b/%b/%b want 1/1/0", done, err, bus.ftam_req.cyc); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp_tid;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         exp_tid = (i < 15) ? 4'(i + 1) : 4'd1;
         issue(1'b0, 32'h0000_5000 + 32'(i * 4), 4'd4, 64'd0);
         wait_cyc(cap, ok);
         n_vec++; if (!ok || cap.tid.tranid !== exp_tid) begin n_bad++; $display("FAIL b2b_tid[%0d] got %b/%0d want 1/%0d", i, ok, cap.tid.tranid, exp_tid); end
         respond(1, 1'b1, 1'b0, 1'b0, cap.tid.tranid, '0);
         n_vec++; if (done !== 1'b1) begin n_bad++; $display("FAIL b2b_done[%0d] got %b want 1", i, done); end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      issue(1'b0, 32'h0000_100E, 4'd4, 64'd0);
      wait_cyc(cap, ok);
      respond(1, 1'b1, 1'b0, 1'b0, 4'd1, '0);
      wait_cyc(cap, ok);
      n_vec++; if (!ok || cap.tid.tranid !== 4'd2) begin n_bad++; $display("FAIL rstm_half2 got %b/%0d want 1/2", ok, cap.tid.tranid); end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_vec++; if (busy !== 1'b0 || done !== 1'b0 || bus.ftam_req.cyc !== 1'b0) begin n_bad++; $display("FAIL rstm_abort got %b/%b/%b want 0/0/0", busy, done, bus.ftam_req.cyc); end
      respond(0, 1'b1, 1'b0, 1'b0, 4'd2, '0);
      n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL rstm_late got %b want 0", done); end
      issue(1'b0, 32'h0000_6000, 4'd4, 64'd0);
      wait_cyc(cap, ok);
      n_vec++; if (!ok || cap.tid.tranid !== 4'd1) begin n_bad++; $display("FAIL rstm_tid got %b/%0d want 1/1", ok, cap.tid.tranid); end
      respond(1, 1'b1, 1'b0, 1'b0, 4'd1, '0);
   endtask

   initial begin
      test_reset();
      test_read();
      test_split_write();
      test_split_read_wrap();
      test_retry();
      test_timeout();
      test_bad_size();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

endmodule
